// File: rtl/iram_loader.sv
// Streams a length-prefixed program image into the IRAM write port and holds the core until done.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the error flag.
module iram_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [8:0]        byte_count
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE} state_t;
`endif

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state, state_next;
    logic [8:0]        remaining;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              start_ok;
    logic              error_q;

    assign accept   = in_valid && in_ready;
    assign start_ok = load_start && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // DATA lingers one cycle with remaining==0 so DONE follows the final write.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        core_hold  = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (load_start) state_next = S_LEN;
            end
            S_LEN: begin
                in_ready  = 1'b1;
                core_hold = 1'b1;
                if (in_valid) state_next = S_DATA;
            end
            S_DATA: begin
                in_ready  = (remaining != 9'd0);
                core_hold = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                if (remaining == 9'd0) state_next = S_CHK;
`else
                if (remaining == 9'd0) state_next = S_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready  = 1'b1;
                core_hold = 1'b1;
                if (in_valid) state_next = S_DONE;
            end
`endif
            S_DONE: begin
                done      = 1'b1;
                core_hold = error_q;
                if (load_start) state_next = S_LEN;
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] xor_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            xor_acc <= '0;
            error_q <= 1'b0;
        end else begin
            if (start_ok) begin
                xor_acc <= '0;
                error_q <= 1'b0;
            end else if (state == S_DATA && accept) begin
                xor_acc <= xor_acc ^ in_data;
            end else if (state == S_CHK && accept) begin
                error_q <= (in_data != xor_acc);
            end
        end
    end
`else
    assign error_q = 1'b0;
`endif

    assign error = error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining   <= '0;
            ptr         <= BASE;
            ram_address <= BASE;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            byte_count  <= '0;
        end else begin
            ram_wren <= 1'b0;
            if (start_ok) byte_count <= '0;
            if (state == S_LEN && accept) begin
                remaining <= (in_data == '0) ? 9'd256 : 9'(in_data);
                ptr       <= BASE;
            end
            if (state == S_DATA && accept) begin
                ram_wren    <= 1'b1;
                ram_address <= ptr;
                ram_data    <= in_data;
                ptr         <= ptr + 1'b1;
                remaining   <= remaining - 9'd1;
                byte_count  <= byte_count + 9'd1;
            end
        end
    end

endmodule
